// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the pipelined core: tracks in-flight destinations and picks stall vs forward.
// Optional forwarding is enabled with the HAZARD_FORWARD_EN macro.
module hazard_scoreboard #(
    parameter int REG_AW   = 5,
    parameter int STAGES   = 3,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           id_valid,
    input  logic [REG_AW-1:0]              id_rs,
    input  logic                           id_rs_use,
    input  logic [REG_AW-1:0]              id_rt,
    input  logic                           id_rt_use,
    input  logic [REG_AW-1:0]              id_rd,
    input  logic                           id_wr,
    input  logic                           id_load,
    input  logic                           flush,
    output logic                           stall,
    output logic                           id_ex_clear,
    output logic [$clog2(STAGES+1)-1:0]    fwd_rs,
    output logic [$clog2(STAGES+1)-1:0]    fwd_rt,
    output logic [CNT_W-1:0]               stall_cnt
);

    localparam int FW = $clog2(STAGES+1);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] ld_q;
    logic [REG_AW-1:0] rd_q [STAGES];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              v0_d;

    logic          rs_need, rt_need;
    logic          rs_hit, rt_hit;
    logic          rs_ok, rt_ok;
    logic          rs_early, rt_early;
    logic [FW-1:0] rs_fwd, rt_fwd;
    logic          rs_haz, rt_haz;

    assign rs_need = id_rs_use && (id_rs != '0);
    assign rt_need = id_rt_use && (id_rt != '0);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        rs_hit   = 1'b0;
        rs_ok    = 1'b0;
        rs_early = 1'b0;
        rs_fwd   = '0;
        rt_hit   = 1'b0;
        rt_ok    = 1'b0;
        rt_early = 1'b0;
        rt_fwd   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (v_q[k] && (rd_q[k] == id_rs)) begin
                rs_hit = 1'b1;
                rs_ok  = !ld_q[k] || (k >= LOAD_LAT);
                rs_fwd = FW'(k + 1);
                if (k < STAGES - 1) rs_early = 1'b1;
            end
            if (v_q[k] && (rd_q[k] == id_rt)) begin
                rt_hit = 1'b1;
                rt_ok  = !ld_q[k] || (k >= LOAD_LAT);
                rt_fwd = FW'(k + 1);
                if (k < STAGES - 1) rt_early = 1'b1;
            end
        end
    end

`ifdef HAZARD_FORWARD_EN
    logic unused_early;
    assign unused_early = rs_early ^ rt_early;
    assign rs_haz = rs_need && rs_hit && !rs_ok;
    assign rt_haz = rt_need && rt_hit && !rt_ok;
    assign fwd_rs = (!stall && rs_need && rs_hit && rs_ok) ? rs_fwd : '0;
    assign fwd_rt = (!stall && rt_need && rt_hit && rt_ok) ? rt_fwd : '0;
`else
    // Without forwarding, WB is covered by write-before-read in the regfile.
    logic unused_fwd;
    assign unused_fwd = ^{rs_fwd, rt_fwd, rs_ok, rt_ok, rs_hit, rt_hit};
    assign rs_haz = rs_need && rs_early;
    assign rt_haz = rt_need && rt_early;
    assign fwd_rs = '0;
    assign fwd_rt = '0;
`endif

    assign stall       = id_valid && !flush && (rs_haz || rt_haz);
    assign id_ex_clear = stall || flush;
    assign stall_cnt   = cnt_q;

    assign v0_d  = id_valid && !stall && !flush && id_wr && (id_rd != '0);
    assign cnt_d = (stall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            ld_q  <= '0;
            cnt_q <= '0;
            for (int k = 0; k < STAGES; k++) rd_q[k] <= '0;
        end else begin
            v_q     <= {v_q[STAGES-2:0], v0_d};
            ld_q    <= {ld_q[STAGES-2:0], v0_d && id_load};
            rd_q[0] <= id_rd;
            for (int k = 1; k < STAGES; k++) rd_q[k] <= rd_q[k-1];
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: default instance plus a STAGES=5 / CNT_W=2 instance.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       id_valid, id_rs_use, id_rt_use, id_wr, id_load, flush;
    logic [4:0] id_rs, id_rt, id_rd;

    logic        stall, clr;
    logic [1:0]  fwd_rs, fwd_rt;
    logic [15:0] cnt;
    logic        stall5, clr5;
    logic [2:0]  fwd_rs5, fwd_rt5;
    logic [1:0]  cnt5;

    int nchk = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
        .id_rt(id_rt), .id_rt_use(id_rt_use), .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
        .flush(flush), .stall(stall), .id_ex_clear(clr), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt),
        .stall_cnt(cnt)
    );

    hazard_scoreboard #(.STAGES(5), .CNT_W(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_use(id_rs_use),
        .id_rt(id_rt), .id_rt_use(id_rt_use), .id_rd(id_rd), .id_wr(id_wr), .id_load(id_load),
        .flush(flush), .stall(stall5), .id_ex_clear(clr5), .fwd_rs(fwd_rs5), .fwd_rt(fwd_rt5),
        .stall_cnt(cnt5)
    );

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic fl);
        id_valid = v; id_rs = rs; id_rs_use = rsu; id_rt = rt; id_rt_use = rtu;
        id_rd = rd; id_wr = wr; id_load = ld; flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        #1 rst_n = 1'b0;
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
        #2;
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL reset_stall: got %0b expected 0", stall); end
        nchk++; if (fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin nfail++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_rs, fwd_rt); end
        nchk++; if (cnt !== 16'd0 || cnt5 !== 2'd0) begin nfail++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt, cnt5); end
        tick();
        nchk++; if (clr !== 1'b0) begin nfail++; $display("FAIL reset_clear: got %0b expected 0", clr); end
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_raw_alu();
        do_reset();
        drive(1, 1, 1, 2, 1, 3, 1, 0, 0);
        #1;
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL alu_first: got %0b expected 0", stall); end
        tick();
        drive(1, 3, 1, 3, 1, 4, 1, 0, 0);
        #1;
`ifdef HAZARD_FORWARD_EN
        nchk++; if (stall !== 1'b0 || fwd_rs !== 2'd1 || fwd_rt !== 2'd1) begin nfail++; $display("FAIL alu_fwd_ex: got stall=%0b fwd=%0d/%0d expected 0 1/1", stall, fwd_rs, fwd_rt); end
        tick();
        drive(1, 3, 1, 0, 0, 5, 1, 0, 0);
        #1;
        nchk++; if (stall !== 1'b0 || fwd_rs !== 2'd2) begin nfail++; $display("FAIL alu_fwd_mem: got stall=%0b fwd=%0d expected 0 2", stall, fwd_rs); end
        nchk++; if (cnt !== 16'd0) begin nfail++; $display("FAIL alu_cnt: got %0d expected 0", cnt); end
`else
        nchk++; if (stall !== 1'b1 || clr !== 1'b1 || fwd_rs !== 2'd0) begin nfail++; $display("FAIL raw_stall1: got stall=%0b clr=%0b fwd=%0d expected 1 1 0", stall, clr, fwd_rs); end
        tick();
        nchk++; if (stall !== 1'b1) begin nfail++; $display("FAIL raw_stall2: got %0b expected 1", stall); end
        tick();
        nchk++; if (stall !== 1'b0 || fwd_rs !== 2'd0 || fwd_rt !== 2'd0) begin nfail++; $display("FAIL raw_release: got stall=%0b fwd=%0d/%0d expected 0 0/0", stall, fwd_rs, fwd_rt); end
        nchk++; if (cnt !== 16'd2) begin nfail++; $display("FAIL raw_cnt: got %0d expected 2", cnt); end
`endif
        tick();
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 29, 1, 0, 0, 8, 1, 1, 0);
        tick();
        drive(1, 8, 1, 0, 1, 9, 1, 0, 0);
        #1;
        nchk++; if (stall !== 1'b1 || clr !== 1'b1 || fwd_rs !== 2'd0) begin nfail++; $display("FAIL lu_stall: got stall=%0b clr=%0b fwd=%0d expected 1 1 0", stall, clr, fwd_rs); end
        tick();
`ifdef HAZARD_FORWARD_EN
        nchk++; if (stall !== 1'b0 || clr !== 1'b0 || fwd_rs !== 2'd2 || fwd_rt !== 2'd0) begin nfail++; $display("FAIL lu_fwd: got stall=%0b clr=%0b fwd=%0d/%0d expected 0 0 2/0", stall, clr, fwd_rs, fwd_rt); end
        nchk++; if (cnt !== 16'd1) begin nfail++; $display("FAIL lu_cnt: got %0d expected 1", cnt); end
`else
        nchk++; if (stall !== 1'b1) begin nfail++; $display("FAIL lu_stall2: got %0b expected 1", stall); end
        tick();
        nchk++; if (stall !== 1'b0 || fwd_rs !== 2'd0) begin nfail++; $display("FAIL lu_release: got stall=%0b fwd=%0d expected 0 0", stall, fwd_rs); end
        nchk++; if (cnt !== 16'd2) begin nfail++; $display("FAIL lu_cnt: got %0d expected 2", cnt); end
`endif
        tick();
        idle();
    endtask

    task automatic test_zero_and_flush();
        do_reset();
        drive(1, 1, 1, 2, 1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 1, 0, 1, 6, 1, 0, 0);
        #1;
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL zero_reg: got %0b expected 0", stall); end
        tick();
        drive(1, 6, 0, 6, 0, 9, 1, 0, 0);
        #1;
        nchk++; if (stall !== 1'b0) begin nfail++; $display("FAIL unused_src: got %0b expected 0", stall); end
        tick();
        drive(1, 9, 1, 0, 0, 10, 1, 1, 1);
        #1;
        nchk++; if (stall !== 1'b0 || clr !== 1'b1) begin nfail++; $display("FAIL flush_prio: got stall=%0b clr=%0b expected 0 1", stall, clr); end
        tick();
        drive(1, 10, 1, 0, 0, 11, 1, 0, 0);
        #1;
        nchk++; if (stall !== 1'b0 || clr !== 1'b0) begin nfail++; $display("FAIL flushed_squashed: got stall=%0b clr=%0b expected 0 0", stall, clr); end
        nchk++; if (cnt !== 16'd0) begin nfail++; $display("FAIL flush_cnt: got %0d expected 0", cnt); end
        idle();
        tick();
    endtask

    task automatic test_youngest();
        do_reset();
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 10, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 20, 1, 0, 0); tick();
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
        #1;
`ifdef HAZARD_FORWARD_EN
        nchk++; if (stall5 !== 1'b0 || fwd_rs5 !== 3'd2) begin nfail++; $display("FAIL young_alu: got stall=%0b fwd=%0d expected 0 2", stall5, fwd_rs5); end
`else
        nchk++; if (stall5 !== 1'b1 || fwd_rs5 !== 3'd0) begin nfail++; $display("FAIL young_alu: got stall=%0b fwd=%0d expected 1 0", stall5, fwd_rs5); end
`endif
        idle();
        do_reset();
        drive(1, 0, 0, 0, 0, 11, 1, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 11, 1, 1, 0); tick();
        drive(1, 0, 0, 11, 1, 0, 0, 0, 0);
        #1;
        nchk++; if (stall5 !== 1'b1 || fwd_rt5 !== 3'd0) begin nfail++; $display("FAIL young_load: got stall=%0b fwd=%0d expected 1 0", stall5, fwd_rt5); end
        idle();
        do_reset();
        drive(1, 0, 0, 0, 0, 12, 1, 0, 0); tick();
        idle(); tick(); tick(); tick();
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
        #1;
`ifdef HAZARD_FORWARD_EN
        nchk++; if (stall5 !== 1'b0 || fwd_rs5 !== 3'd4) begin nfail++; $display("FAIL deep_k3: got stall=%0b fwd=%0d expected 0 4", stall5, fwd_rs5); end
`else
        nchk++; if (stall5 !== 1'b1 || fwd_rs5 !== 3'd0) begin nfail++; $display("FAIL deep_k3: got stall=%0b fwd=%0d expected 1 0", stall5, fwd_rs5); end
`endif
        idle();
        tick();
        drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
        #1;
`ifdef HAZARD_FORWARD_EN
        nchk++; if (stall5 !== 1'b0 || fwd_rs5 !== 3'd5) begin nfail++; $display("FAIL deep_wb: got stall=%0b fwd=%0d expected 0 5", stall5, fwd_rs5); end
`else
        nchk++; if (stall5 !== 1'b0 || fwd_rs5 !== 3'd0) begin nfail++; $display("FAIL deep_wb: got stall=%0b fwd=%0d expected 0 0", stall5, fwd_rs5); end
`endif
        idle();
        tick();
    endtask

    task automatic test_saturate();
        int nst = 0;
        int exp_st;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            int guard = 0;
            drive(1, (i == 0) ? 5'd0 : 5'(i + 1), (i != 0), 0, 0, 5'(i + 2), 1, 1, 0);
            #1;
            while (stall5 === 1'b1 && guard < 10) begin
                nst++;
                guard++;
                tick();
            end
            if (guard >= 10) begin
                nchk++; nfail++;
                $display("FAIL sat_timeout: got stall held %0d cycles expected release", guard);
            end
            tick();
        end
        idle();
`ifdef HAZARD_FORWARD_EN
        exp_st = 5;
`else
        exp_st = 20;
`endif
        nchk++; if (nst !== exp_st) begin nfail++; $display("FAIL sat_stalls: got %0d expected %0d", nst, exp_st); end
        nchk++; if (cnt5 !== 2'd3) begin nfail++; $display("FAIL sat_cnt: got %0d expected 3", cnt5); end
        tick();
    endtask

    task automatic test_reset_midstall();
        do_reset();
        drive(1, 29, 1, 0, 0, 8, 1, 1, 0);
        tick();
        drive(1, 8, 1, 0, 1, 9, 1, 0, 0);
        #1;
        nchk++; if (stall !== 1'b1) begin nfail++; $display("FAIL mid_pre: got %0b expected 1", stall); end
        #2 rst_n = 1'b0;
        #1;
        nchk++; if (stall !== 1'b0 || clr !== 1'b0 || cnt !== 16'd0) begin nfail++; $display("FAIL mid_reset: got stall=%0b clr=%0b cnt=%0d expected 0 0 0", stall, clr, cnt); end
        idle();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        test_reset();
        test_raw_alu();
        test_load_use();
        test_zero_and_flush();
        test_youngest();
        test_saturate();
        test_reset_midstall();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
